// File: rtl/multi_chan_stats_logger.sv
// Per-channel byte/request counters snapshotted every RECORD_PERIOD cycles into a
// ring buffer, read back through a request/response handshake.
// Build option: define STATS_SATURATE_EN for saturating counters (default build wraps).
module multi_chan_stats_logger #(
    parameter int unsigned NUM_CHANS     = 4,
    parameter int unsigned CNT_W         = 64,
    parameter int unsigned TIMESTAMP_W   = 64,
    parameter int unsigned DEPTH_LOG2    = 8,
    parameter int unsigned RECORD_PERIOD = 125000000,
    parameter int unsigned BYTES_INC_W   = 16,
    localparam int unsigned CHAN_W = (NUM_CHANS > 1) ? $clog2(NUM_CHANS) : 1,
    localparam int unsigned DATA_W = TIMESTAMP_W + 2 * CNT_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CHANS-1:0]             ev_val,
    input  logic [NUM_CHANS*BYTES_INC_W-1:0] ev_bytes,
    input  logic [NUM_CHANS-1:0]             ev_req_done,
    input  logic                             rd_req_val,
    output logic                             rd_req_rdy,
    input  logic [DEPTH_LOG2-1:0]            rd_req_idx,
    input  logic [CHAN_W-1:0]                rd_req_chan,
    output logic                             rd_resp_val,
    input  logic                             rd_resp_rdy,
    output logic [DATA_W-1:0]                rd_resp_data,
    output logic                             rd_resp_hit,
    output logic [DEPTH_LOG2-1:0]            wr_ptr,
    output logic [DEPTH_LOG2:0]              rec_count
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned PER_W = $clog2(RECORD_PERIOD);
    localparam int unsigned REC_W = DEPTH_LOG2 + 1;
    localparam int unsigned SUM_W = ((CNT_W > BYTES_INC_W) ? CNT_W : BYTES_INC_W) + 1;
    localparam logic [REC_W-1:0] REC_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_RESP
    } state_e;

    logic [TIMESTAMP_W-1:0]            ts_q;
    logic [PER_W-1:0]                  period_q;
    logic [NUM_CHANS-1:0][CNT_W-1:0]   bytes_q, bytes_d;
    logic [NUM_CHANS-1:0][CNT_W-1:0]   reqs_q, reqs_d;
    logic [DEPTH_LOG2-1:0]             wr_ptr_q;
    logic [REC_W-1:0]                  rec_count_q;
    logic                              snap_now;

    logic [TIMESTAMP_W-1:0]            ts_mem    [DEPTH];
    logic [NUM_CHANS-1:0][CNT_W-1:0]   bytes_mem [DEPTH];
    logic [NUM_CHANS-1:0][CNT_W-1:0]   reqs_mem  [DEPTH];

    state_e                            state_q;
    logic [DEPTH_LOG2-1:0]             idx_q;
    logic [CHAN_W-1:0]                 chan_q;
    logic                              rdy_q;
    logic                              val_q;
    logic                              hit_q;
    logic [DATA_W-1:0]                 data_q;

    logic                              chan_ok;
    logic [CHAN_W-1:0]                 chan_sel;
    logic [DEPTH_LOG2-1:0]             age;
    logic                              rd_hit;

    // Counter add: wraps modulo 2^CNT_W, or clamps at all-ones when saturating.
    function automatic logic [CNT_W-1:0] add_cnt(input logic [CNT_W-1:0] cnt,
                                                  input logic [SUM_W-1:0] inc);
        logic [SUM_W-1:0] sum;
        sum     = SUM_W'(cnt) + inc;
        add_cnt = CNT_W'(sum);
`ifdef STATS_SATURATE_EN
        if (sum[SUM_W-1:CNT_W] != '0) begin
            add_cnt = '1;
        end
`endif
    endfunction

    assign snap_now = (period_q == PER_W'(RECORD_PERIOD - 1));

    always_comb begin
        bytes_d = bytes_q;
        reqs_d  = reqs_q;
        for (int c = 0; c < NUM_CHANS; c++) begin
            if (ev_val[c]) begin
                bytes_d[c] = add_cnt(bytes_q[c], SUM_W'(ev_bytes[c*BYTES_INC_W +: BYTES_INC_W]));
                reqs_d[c]  = add_cnt(reqs_q[c], SUM_W'(ev_req_done[c]));
            end
        end
    end

    // Timestamp, period, counters and ring-buffer bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q        <= '0;
            period_q    <= '0;
            bytes_q     <= '0;
            reqs_q      <= '0;
            wr_ptr_q    <= '0;
            rec_count_q <= '0;
        end else begin
            ts_q     <= ts_q + TIMESTAMP_W'(1);
            period_q <= snap_now ? '0 : period_q + PER_W'(1);
            bytes_q  <= bytes_d;
            reqs_q   <= reqs_d;
            if (snap_now) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
                if (rec_count_q != REC_FULL) begin
                    rec_count_q <= rec_count_q + REC_W'(1);
                end
            end
        end
    end

    // Snapshot storage captures pre-increment counter values.
    always_ff @(posedge clk) begin
        if (snap_now) begin
            ts_mem[wr_ptr_q]    <= ts_q;
            bytes_mem[wr_ptr_q] <= bytes_q;
            reqs_mem[wr_ptr_q]  <= reqs_q;
        end
    end

    assign chan_ok  = ({1'b0, chan_q} < (CHAN_W + 1)'(NUM_CHANS));
    assign chan_sel = chan_ok ? chan_q : '0;
    assign age      = wr_ptr_q - DEPTH_LOG2'(1) - idx_q;
    assign rd_hit   = chan_ok && ({1'b0, age} < rec_count_q);

    // Read FSM; rdy comes up one edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            chan_q  <= '0;
            rdy_q   <= 1'b0;
            val_q   <= 1'b0;
            hit_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rd_req_val && rdy_q) begin
                        idx_q   <= rd_req_idx;
                        chan_q  <= rd_req_chan;
                        rdy_q   <= 1'b0;
                        state_q <= S_RD;
                    end else begin
                        rdy_q <= 1'b1;
                    end
                end
                S_RD: begin
                    hit_q   <= rd_hit;
                    data_q  <= rd_hit ? {ts_mem[idx_q], bytes_mem[idx_q][chan_sel],
                                         reqs_mem[idx_q][chan_sel]} : '0;
                    val_q   <= 1'b1;
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    if (rd_resp_rdy) begin
                        val_q   <= 1'b0;
                        rdy_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_req_rdy   = rdy_q;
    assign rd_resp_val  = val_q;
    assign rd_resp_hit  = hit_q;
    assign rd_resp_data = data_q;
    assign wr_ptr       = wr_ptr_q;
    assign rec_count    = rec_count_q;

endmodule

// File: tb/tb_multi_chan_stats_logger.sv
// Bench for multi_chan_stats_logger: directed read table, multi-cycle corner
// sequences, and randomized traffic against a snapshot-history reference model.
`timescale 1ns/1ps
module tb_multi_chan_stats_logger;

    localparam int unsigned NC    = 3;
    localparam int unsigned CW    = 16;
    localparam int unsigned TW    = 16;
    localparam int unsigned DL    = 2;
    localparam int unsigned RP    = 10;
    localparam int unsigned BW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CHW   = 2;
    localparam int unsigned DW    = TW + 2 * CW;
    localparam int unsigned EVB_W = NC * BW;

    logic clk = 1'b0;
    logic rst_n;

    logic [NC-1:0]    ev_val      = '0;
    logic [EVB_W-1:0] ev_bytes    = '0;
    logic [NC-1:0]    ev_req_done = '0;
    logic             rd_req_val, rd_req_rdy, rd_resp_val, rd_resp_rdy, rd_resp_hit;
    logic [DL-1:0]    rd_req_idx;
    logic [CHW-1:0]   rd_req_chan;
    logic [DW-1:0]    rd_resp_data;
    logic [DL-1:0]    wr_ptr;
    logic [DL:0]      rec_count;

    logic [1:0]  b_ev_val = '0;
    logic [15:0] b_ev_bytes = '0;
    logic [1:0]  b_ev_req_done = '0;
    logic        b_rd_req_val, b_rd_req_rdy, b_rd_resp_val, b_rd_resp_rdy, b_rd_resp_hit;
    logic [0:0]  b_rd_req_idx;
    logic [0:0]  b_rd_req_chan;
    logic [23:0] b_rd_resp_data;
    logic [0:0]  b_wr_ptr;
    logic [1:0]  b_rec_count;

    int errors = 0;
    int checks = 0;
    int ev_mode = 1;

    multi_chan_stats_logger #(
        .NUM_CHANS(NC), .CNT_W(CW), .TIMESTAMP_W(TW), .DEPTH_LOG2(DL),
        .RECORD_PERIOD(RP), .BYTES_INC_W(BW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ev_val(ev_val), .ev_bytes(ev_bytes),
        .ev_req_done(ev_req_done), .rd_req_val(rd_req_val), .rd_req_rdy(rd_req_rdy),
        .rd_req_idx(rd_req_idx), .rd_req_chan(rd_req_chan), .rd_resp_val(rd_resp_val),
        .rd_resp_rdy(rd_resp_rdy), .rd_resp_data(rd_resp_data), .rd_resp_hit(rd_resp_hit),
        .wr_ptr(wr_ptr), .rec_count(rec_count)
    );

    multi_chan_stats_logger #(
        .NUM_CHANS(2), .CNT_W(8), .TIMESTAMP_W(8), .DEPTH_LOG2(1),
        .RECORD_PERIOD(4), .BYTES_INC_W(8)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .ev_val(b_ev_val), .ev_bytes(b_ev_bytes),
        .ev_req_done(b_ev_req_done), .rd_req_val(b_rd_req_val), .rd_req_rdy(b_rd_req_rdy),
        .rd_req_idx(b_rd_req_idx), .rd_req_chan(b_rd_req_chan), .rd_resp_val(b_rd_resp_val),
        .rd_resp_rdy(b_rd_resp_rdy), .rd_resp_data(b_rd_resp_data), .rd_resp_hit(b_rd_resp_hit),
        .wr_ptr(b_wr_ptr), .rec_count(b_rec_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // Event driver: mode 1 = directed 100-byte bursts, mode 2 = random, else idle.
    always @(negedge clk) begin
        ev_val = '0; ev_bytes = '0; ev_req_done = '0;
        b_ev_val = '0; b_ev_bytes = '0; b_ev_req_done = '0;
        if (ev_mode == 2) begin
            ev_val      = NC'($urandom);
            ev_bytes    = EVB_W'($urandom);
            ev_req_done = NC'($urandom);
        end else if (ev_mode == 1) begin
            ev_val        = 3'b001;
            ev_bytes      = EVB_W'(100);
            ev_req_done   = 3'b001;
            b_ev_val      = 2'b10;
            b_ev_bytes    = {8'd100, 8'd0};
            b_ev_req_done = 2'b10;
        end
    end

    // Reference model: running totals since reset plus the full snapshot history.
    typedef struct packed {
        logic [TW-1:0]         ts;
        logic [NC-1:0][CW-1:0] b;
        logic [NC-1:0][CW-1:0] r;
    } snap_t;

    longint unsigned m_cyc;
    longint unsigned m_bytes [NC];
    longint unsigned m_reqs  [NC];
    snap_t           snaps [$];

    function automatic logic [CW-1:0] reduce(input longint unsigned tot);
`ifdef STATS_SATURATE_EN
        return (tot > 65535) ? CW'(65535) : CW'(tot);
`else
        return CW'(tot % 65536);
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0;
            for (int c = 0; c < NC; c++) begin m_bytes[c] = 0; m_reqs[c] = 0; end
            snaps.delete();
        end else begin
            if (m_cyc % RP == RP - 1) begin
                snap_t s;
                s.ts = TW'(m_cyc % 65536);
                for (int c = 0; c < NC; c++) begin
                    s.b[c] = reduce(m_bytes[c]);
                    s.r[c] = reduce(m_reqs[c]);
                end
                snaps.push_back(s);
            end
            for (int c = 0; c < NC; c++) begin
                if (ev_val[c]) begin
                    m_bytes[c] += longint'(ev_bytes[c*BW +: BW]);
                    m_reqs[c]  += longint'(ev_req_done[c]);
                end
            end
            m_cyc++;
        end
    end

    // The newest snapshot k with k mod DEPTH == idx among the last DEPTH taken.
    function automatic void expect_read(input int n, input int idx, input int chan,
                                        output logic hit, output logic [DW-1:0] data);
        hit = 1'b0;
        data = '0;
        if (chan < NC) begin
            for (int k = n - 1; k >= 0 && k >= n - int'(DEPTH); k--) begin
                if (k % DEPTH == idx) begin
                    hit  = 1'b1;
                    data = {snaps[k].ts, snaps[k].b[chan], snaps[k].r[chan]};
                end
            end
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input longint unsigned target);
        int guard = 0;
        while (m_cyc < target && guard < 2000) begin @(negedge clk); guard++; end
        check("wait_cycle_reached", 64'(m_cyc >= target), 64'd1);
    endtask

    // Called at a negedge; returns response fields and the model snapshot count at accept.
    task automatic do_read(input int idx, input int chan, input int hold,
                           output logic hit, output logic [DW-1:0] data, output int n_acc);
        int w = 0;
        logic stable = 1'b1;
        rd_req_idx  = DL'(idx);
        rd_req_chan = CHW'(chan);
        rd_req_val  = 1'b1;
        while (rd_req_rdy !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        check("req_rdy_seen", 64'(rd_req_rdy), 64'd1);
        @(posedge clk);
        #1 n_acc = snaps.size();
        @(negedge clk);
        rd_req_val = 1'b0;
        check("resp_val_after_1", 64'(rd_resp_val), 64'd0);
        @(negedge clk);
        check("resp_val_after_2", 64'(rd_resp_val), 64'd1);
        hit  = rd_resp_hit;
        data = rd_resp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rd_resp_data !== data || rd_resp_val !== 1'b1 || rd_resp_hit !== hit) stable = 1'b0;
        end
        check("resp_hold_stable", 64'(stable), 64'd1);
        rd_resp_rdy = 1'b1;
        @(negedge clk);
        rd_resp_rdy = 1'b0;
        check("resp_val_dropped", 64'(rd_resp_val), 64'd0);
    endtask

    typedef struct {
        int          idx;
        int          chan;
        logic        hit;
        logic [DW-1:0] data;
    } rd_vec_t;

    rd_vec_t tbl [6];

    initial begin
        logic          hit, ehit;
        logic [DW-1:0] data, edata;
        int            n_acc, w, exp_b;

        tbl[0] = '{1, 0, 1'b0, DW'(0)};
        tbl[1] = '{3, 0, 1'b0, DW'(0)};
        tbl[2] = '{0, 0, 1'b1, {16'd9, 16'd300, 16'd3}};
        tbl[3] = '{0, 1, 1'b1, {16'd9, 16'd0, 16'd0}};
        tbl[4] = '{0, 2, 1'b1, {16'd9, 16'd0, 16'd0}};
        tbl[5] = '{0, 3, 1'b0, DW'(0)};

        rst_n = 1'b1;
        rd_req_val = 1'b0; rd_resp_rdy = 1'b0; rd_req_idx = '0; rd_req_chan = '0;
        b_rd_req_val = 1'b0; b_rd_resp_rdy = 1'b0; b_rd_req_idx = '0; b_rd_req_chan = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_rdy", 64'(rd_req_rdy), 64'd0);
        check("rst_resp_val", 64'(rd_resp_val), 64'd0);
        check("rst_resp_data", 64'(rd_resp_data), 64'd0);
        check("rst_resp_hit", 64'(rd_resp_hit), 64'd0);
        check("rst_wr_ptr", 64'(wr_ptr), 64'd0);
        check("rst_rec_count", 64'(rec_count), 64'd0);

        // Three 100-byte events land on the first three edges after release.
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 ev_mode = 0;
        wait_cyc(11);
        check("first_snap_wr_ptr", 64'(wr_ptr), 64'd1);
        check("first_snap_rec_count", 64'(rec_count), 64'd1);

        for (int i = 0; i < 6; i++) begin
            do_read(tbl[i].idx, tbl[i].chan, 0, hit, data, n_acc);
            check($sformatf("tbl%0d_hit", i), 64'(hit), 64'(tbl[i].hit));
            check($sformatf("tbl%0d_data", i), 64'(data), 64'(tbl[i].data));
        end

        // Narrow-counter instance: three 100-byte events on channel 1.
`ifdef STATS_SATURATE_EN
        exp_b = 255;
`else
        exp_b = 44;
`endif
        b_rd_req_idx = 1'b0; b_rd_req_chan = 1'b1; b_rd_req_val = 1'b1;
        w = 0;
        while (b_rd_req_rdy !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        @(posedge clk);
        @(negedge clk);
        b_rd_req_val = 1'b0;
        @(negedge clk);
        check("b_resp_val", 64'(b_rd_resp_val), 64'd1);
        check("b_resp_hit", 64'(b_rd_resp_hit), 64'd1);
        check("b_bytes_narrow", 64'(b_rd_resp_data[15:8]), 64'(exp_b));
        check("b_reqs_narrow", 64'(b_rd_resp_data[7:0]), 64'd3);
        b_rd_resp_rdy = 1'b1;
        @(negedge clk);
        b_rd_resp_rdy = 1'b0;

        // Six periods into a four-slot ring: slot 0 now holds the fifth snapshot.
        wait_cyc(62);
        check("wrap_rec_count", 64'(rec_count), 64'd4);
        check("wrap_wr_ptr", 64'(wr_ptr), 64'd2);
        do_read(0, 0, 0, hit, data, n_acc);
        check("wrap_slot0_hit", 64'(hit), 64'd1);
        check("wrap_slot0_data", 64'(data), 64'({16'd49, 16'd300, 16'd3}));

        // Long backpressure spanning snapshots.
        do_read(1, 0, 20, hit, data, n_acc);
        check("bp_slot1_data", 64'(data), 64'({16'd59, 16'd300, 16'd3}));
        check("bp_snap_wr_ptr", 64'(wr_ptr), 64'(snaps.size() % DEPTH));
        check("bp_snap_advanced", 64'(snaps.size() > n_acc + 1), 64'd1);
        check("bp_rec_count", 64'(rec_count), 64'd4);

        // Randomized traffic and reads against the model.
        ev_mode = 2;
        for (int i = 0; i < 160; i++) begin
            repeat ($urandom_range(5, 0)) @(negedge clk);
            begin
                int ridx, rchan;
                ridx  = int'($urandom_range(DEPTH - 1, 0));
                rchan = int'($urandom_range(3, 0));
                do_read(ridx, rchan, int'($urandom_range(3, 0)), hit, data, n_acc);
                expect_read(n_acc, ridx, rchan, ehit, edata);
                check($sformatf("rand%0d_hit(idx%0d,ch%0d)", i, ridx, rchan), 64'(hit), 64'(ehit));
                check($sformatf("rand%0d_data(idx%0d,ch%0d)", i, ridx, rchan), 64'(data), 64'(edata));
            end
        end
        ev_mode = 0;
        check("rand_wr_ptr", 64'(wr_ptr), 64'(snaps.size() % DEPTH));

        // Reset while a response is pending.
        @(negedge clk);
        rd_req_idx = '0; rd_req_chan = '0; rd_req_val = 1'b1;
        w = 0;
        while (rd_req_rdy !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        @(posedge clk);
        @(negedge clk);
        rd_req_val = 1'b0;
        @(negedge clk);
        check("pre_reset_resp_val", 64'(rd_resp_val), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_resp_val", 64'(rd_resp_val), 64'd0);
        check("midrst_resp_data", 64'(rd_resp_data), 64'd0);
        check("midrst_resp_hit", 64'(rd_resp_hit), 64'd0);
        check("midrst_req_rdy", 64'(rd_req_rdy), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_rdy", 64'(rd_req_rdy), 64'd1);
        check("post_rst_resp_val", 64'(rd_resp_val), 64'd0);
        check("post_rst_rec_count", 64'(rec_count), 64'd0);
        check("post_rst_wr_ptr", 64'(wr_ptr), 64'd0);
        do_read(0, 0, 1, hit, data, n_acc);
        check("post_rst_read_hit", 64'(hit), 64'd0);
        check("post_rst_read_data", 64'(data), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
